// File: rtl/aer_pkg.sv
// Shared constants, the AER word layout and the round-robin search helper for aer_spike_encoder.
// The optional timestamp field is controlled by the AER_TIMESTAMP_EN macro.
package aer_pkg;

   localparam int AER_ADDR_W = 4;
   localparam int AER_TS_W   = 16;
   localparam int AER_MAX_N  = 64;
   localparam int AER_IDX_W  = 6;

`ifdef AER_TIMESTAMP_EN
   typedef struct packed {
      logic [AER_ADDR_W-1:0] addr;
      logic [AER_TS_W-1:0]   ts;
   } aer_word_t;
`else
   typedef struct packed {
      logic [AER_ADDR_W-1:0] addr;
   } aer_word_t;
`endif

   typedef struct packed {
      logic                 found;
      logic [AER_IDX_W-1:0] idx;
   } aer_pick_t;

   // Scans from ptr upward, wrapping at n. The loop runs downward so the
   // smallest offset from ptr is the last assignment and wins.
   function automatic aer_pick_t aer_rr_pick(input logic [AER_MAX_N-1:0] req,
                                             input int ptr,
                                             input int n);
      aer_pick_t            pick;
      int                   idx;
      logic [AER_IDX_W-1:0] sel;
      pick = '0;
      for (int k = AER_MAX_N-1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            sel = AER_IDX_W'(idx);
            if (req[sel]) begin
               pick.found = 1'b1;
               pick.idx   = sel;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/aer_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible on dout while not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module aer_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   // Drive zero when empty so the head word reads 0 out of reset.
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/aer_spike_encoder.sv
// Latches spike pulses, grants one pending neuron per cycle round-robin and queues its address.
// Defining AER_TIMESTAMP_EN adds a free-running counter and the aer_ts output.
module aer_spike_encoder
   import aer_pkg::*;
#(
   parameter int N_NEURONS  = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int TS_W       = AER_TS_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [N_NEURONS-1:0]          spike_in,
   output logic                          aer_valid,
   input  logic                          aer_ready,
   output logic [$clog2(N_NEURONS)-1:0]  aer_addr,
`ifdef AER_TIMESTAMP_EN
   output logic [TS_W-1:0]               aer_ts,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int ADDR_W = $clog2(N_NEURONS);
`ifdef AER_TIMESTAMP_EN
   localparam int WORD_W = ADDR_W + TS_W;
`else
   localparam int WORD_W = ADDR_W;
`endif

   logic [N_NEURONS-1:0] pending_q, pending_d;
   logic [N_NEURONS-1:0] grant;
   logic [ADDR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]    grant_idx;
   logic                 grant_vld;
   logic                 overflow_q, overflow_d;
   logic                 fifo_full, fifo_empty;
   logic [WORD_W-1:0]    push_word, head_word;
   aer_pick_t            pick;

   // Stream handshake: aer_valid stays high and aer_addr/aer_ts hold steady until a
   // cycle with aer_valid & aer_ready, which is the one and only transfer of that word.
   assign aer_valid = ~fifo_empty;
   assign overflow  = overflow_q;

   always_comb begin
      pick      = aer_rr_pick(AER_MAX_N'(pending_q), int'(rr_ptr_q), N_NEURONS);
      grant_vld = pick.found & ~fifo_full;
      grant_idx = ADDR_W'(pick.idx);
      grant     = '0;
      if (grant_vld) grant[grant_idx] = 1'b1;
      // A spike landing on the bit being granted starts a fresh event.
      pending_d  = (pending_q & ~grant) | spike_in;
      overflow_d = |(spike_in & pending_q & ~grant);
      rr_ptr_d   = rr_ptr_q;
      if (grant_vld) begin
         rr_ptr_d = (grant_idx == ADDR_W'(N_NEURONS-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q  <= '0;
         rr_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         rr_ptr_q   <= rr_ptr_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef AER_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q, ts_d;

   always_comb begin
      ts_d = ts_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts_q <= '0;
      else          ts_q <= ts_d;
   end

   assign push_word = {grant_idx, ts_q};
   assign aer_addr  = head_word[WORD_W-1 -: ADDR_W];
   assign aer_ts    = head_word[TS_W-1:0];
`else
   assign push_word = grant_idx;
   assign aer_addr  = head_word;
`endif

   aer_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (grant_vld),
      .din     (push_word),
      .full    (fifo_full),
      .pop     (aer_valid & aer_ready),
      .dout    (head_word),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed bench for aer_spike_encoder with hand-computed expectations.
// Defining AER_TIMESTAMP_EN also exercises the timestamp path with TS_W=4.
module tb_aer_spike_encoder;

   localparam int N      = 16;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 4;
   localparam int TS_W   = 4;

   logic              clk       = 1'b0;
   logic              reset_n   = 1'b0;
   logic              aer_ready = 1'b0;
   logic [N-1:0]      spike_in  = '0;
   logic              aer_valid;
   logic              overflow;
   logic [ADDR_W-1:0] aer_addr;
   logic [3:0]        fifo_count;
`ifdef AER_TIMESTAMP_EN
   logic [TS_W-1:0]   aer_ts;
   logic [TS_W-1:0]   exp_ts_q[$];
`endif
   logic [ADDR_W-1:0] exp_q[$];

   int n_vec   = 0;
   int n_err   = 0;
   int ovf_cnt = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   aer_spike_encoder #(
      .N_NEURONS  (N),
      .FIFO_DEPTH (DEPTH),
      .TS_W       (TS_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .spike_in   (spike_in),
      .aer_valid  (aer_valid),
      .aer_ready  (aer_ready),
      .aer_addr   (aer_addr),
`ifdef AER_TIMESTAMP_EN
      .aer_ts     (aer_ts),
`endif
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always @(negedge clk) begin
      if (overflow === 1'b1) ovf_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset(input logic rdy);
      spike_in  = '0;
      aer_ready = rdy;
      reset_n   = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      ovf_cnt = 0;
      exp_q.delete();
   endtask

   task automatic pulse(input logic [N-1:0] bits);
      spike_in = bits;
      @(negedge clk);
      spike_in = '0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         if (aer_valid === 1'b1 && aer_ready === 1'b1) begin
            check("drain_addr", 32'(aer_addr), 32'(exp_q.pop_front()));
`ifdef AER_TIMESTAMP_EN
            check("drain_ts", 32'(aer_ts), 32'(exp_ts_q.pop_front()));
`endif
         end
         @(negedge clk);
         c++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // reset state
      do_reset(1'b1);
      check("rst_valid", 32'(aer_valid), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_addr", 32'(aer_addr), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
`ifdef AER_TIMESTAMP_EN
      check("rst_ts", 32'(aer_ts), 32'd0);
`endif

      // 1: single spike, two-cycle latency, one-cycle word
      repeat (7) @(negedge clk);
      pulse(16'h0020);
      check("t1_valid_t1", 32'(aer_valid), 32'd0);
      @(negedge clk);
      check("t1_valid_t2", 32'(aer_valid), 32'd1);
      check("t1_addr", 32'(aer_addr), 32'd5);
      check("t1_count", 32'(fifo_count), 32'd1);
      @(negedge clk);
      check("t1_valid_t3", 32'(aer_valid), 32'd0);
      check("t1_ovf", 32'(ovf_cnt), 32'd0);

      // 2: all neurons at once drain back-to-back in rr order
      do_reset(1'b1);
      pulse(16'hFFFF);
      check("t2_valid_pre", 32'(aer_valid), 32'd0);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         check("t2_valid", 32'(aer_valid), 32'd1);
         check("t2_addr", 32'(aer_addr), 32'(i));
      end
      @(negedge clk);
      check("t2_valid_post", 32'(aer_valid), 32'd0);
      check("t2_ovf", 32'(ovf_cnt), 32'd0);

      // 3: backpressure fills FIFO, rest stays pending, no loss
      do_reset(1'b0);
      pulse(16'hFFFF);
      repeat (15) @(negedge clk);
      check("t3_count_full", 32'(fifo_count), 32'd8);
      check("t3_head_stable", 32'(aer_addr), 32'd0);
      for (int i = 0; i < N; i++) exp_q.push_back(ADDR_W'(i));
      aer_ready = 1'b1;
      drain(60);
      repeat (2) @(negedge clk);
      check("t3_count_end", 32'(fifo_count), 32'd0);
      check("t3_ovf", 32'(ovf_cnt), 32'd0);

      // 4: repeat spike on a pending neuron overflows once and merges
      do_reset(1'b0);
      pulse(16'h00FF);
      repeat (12) @(negedge clk);
      check("t4_count_full", 32'(fifo_count), 32'd8);
      pulse(16'h0008);
      repeat (3) @(negedge clk);
      check("t4_ovf_first", 32'(ovf_cnt), 32'd0);
      pulse(16'h0008);
      repeat (3) @(negedge clk);
      check("t4_ovf_second", 32'(ovf_cnt), 32'd1);
      for (int i = 0; i < 8; i++) exp_q.push_back(ADDR_W'(i));
      exp_q.push_back(ADDR_W'(3));
      aer_ready = 1'b1;
      drain(40);
      repeat (4) @(negedge clk);
      check("t4_no_extra", 32'(aer_valid), 32'd0);
      check("t4_ovf_total", 32'(ovf_cnt), 32'd1);

      // 5: asynchronous reset discards queued words
      do_reset(1'b0);
      pulse(16'h001F);
      repeat (8) @(negedge clk);
      check("t5_count_q", 32'(fifo_count), 32'd5);
      reset_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(aer_valid), 32'd0);
      check("t5_rst_count", 32'(fifo_count), 32'd0);
      check("t5_rst_addr", 32'(aer_addr), 32'd0);
      @(negedge clk);
      reset_n   = 1'b1;
      aer_ready = 1'b1;
      @(negedge clk);
      pulse(16'h0011);
      exp_q.push_back(ADDR_W'(0));
      exp_q.push_back(ADDR_W'(4));
      drain(20);
      repeat (3) @(negedge clk);
      check("t5_idle", 32'(aer_valid), 32'd0);

`ifdef AER_TIMESTAMP_EN
      // 6: timestamp captured in grant cycle, wraps 15 -> 0
      do_reset(1'b0);
      exp_ts_q.delete();
      repeat (13) @(negedge clk);
      pulse(16'h0004);
      @(negedge clk);
      pulse(16'h0200);
      repeat (3) @(negedge clk);
      check("t6_count", 32'(fifo_count), 32'd2);
      exp_q.push_back(ADDR_W'(2));
      exp_ts_q.push_back(TS_W'(15));
      exp_q.push_back(ADDR_W'(9));
      exp_ts_q.push_back(TS_W'(1));
      aer_ready = 1'b1;
      drain(20);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
